// File: rtl/dmem_pkg.sv
// Shared definitions for the split-access data memory controller.
// Contents: FSM state type, RISC-V load/store func3 codes referenced by the
// fault decode, size-code constant and the size decode helper.
package dmem_pkg;

   // Controller states
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LD1  = 3'd1,
      LD2  = 3'd2,
      ST2  = 3'd3,
      RESP = 3'd4
   } state_e;

   // func3 codes with special handling
   localparam logic [2:0] F3_LWU     = 3'b110;
   localparam logic [2:0] F3_ILLEGAL = 3'b111;

   // func3[1:0] size code for doubleword access
   localparam logic [1:0] SZ_D = 2'b11;

   // Access size in bytes from func3[1:0]
   function automatic logic [3:0] size_bytes(input logic [1:0] sz);
      return 4'(4'd1 << sz);
   endfunction

endpackage

// File: rtl/dmem_bram.sv
// Single-port XLEN-wide RAM with per-byte write enables and a registered read.
// Ports: clk; en_i enables the access; we_i per-byte write enable;
//        addr_i word index; wdata_i write data; rdata_o read data (1-cycle latency).
// Contents are not reset.
module dmem_bram #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned DEPTH = 256
) (
   input  logic                     clk,
   input  logic                     en_i,
   input  logic [XLEN/8-1:0]        we_i,
   input  logic [$clog2(DEPTH)-1:0] addr_i,
   input  logic [XLEN-1:0]          wdata_i,
   output logic [XLEN-1:0]          rdata_o
);

   localparam int unsigned NB = XLEN / 8;

   logic [XLEN-1:0] mem_q [DEPTH];
   logic [XLEN-1:0] rdata_q;

   // Byte-lane writes plus registered read of the addressed word
   always_ff @(posedge clk) begin
      if (en_i) begin
         for (int b = 0; b < NB; b++) begin
            if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_split_ctrl.sv
// Data memory controller that splits misaligned loads/stores into two RAM beats.
// Ports: clk, rst (sync, active high); request req_valid/req_ready/req_we/
//        req_addr/req_func3/req_wdata; response rsp_valid (1-cycle pulse),
//        rsp_rdata (extended load data, 0 otherwise), rsp_err (access fault).
module dmem_split_ctrl
   import dmem_pkg::*;
#(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [2:0]        req_func3,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              rsp_valid,
   output logic [XLEN-1:0]   rsp_rdata,
   output logic              rsp_err
);

   localparam int unsigned NB    = XLEN / 8;
   localparam int unsigned OFF_W = $clog2(NB);
   localparam int unsigned IDX_W = $clog2(DEPTH);

   state_e            state_q, state_d;
   logic              ready_q, ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [XLEN-1:0]   hold_q, hold_d;
   logic [OFF_W-1:0]  off_q, off_d;
   logic [2:0]        f3_q, f3_d;
   logic              split_q, split_d;
   logic [IDX_W-1:0]  idx1_q, idx1_d;
   logic [XLEN-1:0]   wdata_hi_q, wdata_hi_d;
   logic [NB-1:0]     be_hi_q, be_hi_d;

   logic [OFF_W-1:0]  req_off;
   logic [3:0]        req_size;
   logic [4:0]        end_b;
   logic              req_split;
   logic [ADDR_W:0]   w_ext, w_last;
   logic              bad_f3;
   logic              req_fault;
   logic [IDX_W-1:0]  req_idx;
   logic [2*XLEN-1:0] wide_data;
   logic [2*NB-1:0]   wide_be;

   logic              ram_en;
   logic [NB-1:0]     ram_we;
   logic [IDX_W-1:0]  ram_addr;
   logic [XLEN-1:0]   ram_wdata;
   logic [XLEN-1:0]   ram_rdata;

   // Pick the addressed bytes out of a two-word window and sign/zero extend
   function automatic logic [XLEN-1:0] load_extend(input logic [2*XLEN-1:0] pair,
                                                   input logic [OFF_W-1:0]  off,
                                                   input logic [2:0]        f3);
      logic [XLEN-1:0] raw;
      logic [XLEN-1:0] mask;
      logic [6:0]      nbits;
      logic            sgn;
      raw   = XLEN'(pair >> {off, 3'b000});
      nbits = 7'(size_bytes(f3[1:0])) << 3;
      mask  = (nbits >= 7'(XLEN)) ? '1 : ((XLEN'(1) << nbits) - XLEN'(1));
      // mask ^ (mask >> 1) isolates the sign bit position of the access
      sgn   = ~f3[2] & (|(raw & (mask ^ (mask >> 1))));
      return (raw & mask) | (sgn ? ~mask : '0);
   endfunction

   // Request decode: size, offset, split detection and fault checks
   always_comb begin
      req_off   = req_addr[OFF_W-1:0];
      req_size  = size_bytes(req_func3[1:0]);
      end_b     = 5'(req_off) + 5'(req_size);
      req_split = end_b > 5'(NB);
      w_ext     = (ADDR_W+1)'(req_addr >> OFF_W);
      // extra bit keeps W+1 from wrapping back into range
      w_last    = w_ext + (ADDR_W+1)'(req_split);
      bad_f3    = (req_func3 == F3_ILLEGAL) || (req_we && req_func3[2]) ||
                  ((XLEN == 32) && ((req_func3 == F3_LWU) || (req_func3[1:0] == SZ_D)));
      req_fault = bad_f3 || (req_size > 4'(NB)) || (w_last >= (ADDR_W+1)'(DEPTH));
      req_idx   = req_addr[OFF_W +: IDX_W];
      wide_data = (2*XLEN)'(req_wdata) << {req_off, 3'b000};
      wide_be   = (((2*NB)'(1) << req_size) - (2*NB)'(1)) << req_off;
   end

   // Next-state, RAM port control and response generation
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      off_d       = off_q;
      f3_d        = f3_q;
      split_d     = split_q;
      idx1_d      = idx1_q;
      wdata_hi_d  = wdata_hi_q;
      be_hi_d     = be_hi_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
      ram_en      = 1'b0;
      ram_we      = '0;
      ram_addr    = req_idx;
      ram_wdata   = wide_data[XLEN-1:0];

      case (state_q)
         IDLE: begin
            if (req_valid && ready_q) begin
               off_d      = req_off;
               f3_d       = req_func3;
               split_d    = req_split;
               idx1_d     = req_idx + IDX_W'(1);
               wdata_hi_d = wide_data[2*XLEN-1:XLEN];
               be_hi_d    = wide_be[2*NB-1:NB];
               if (req_fault) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else if (req_we) begin
                  ram_en = 1'b1;
                  ram_we = wide_be[NB-1:0];
                  if (req_split) begin
                     state_d = ST2;
                  end else begin
                     state_d     = RESP;
                     rsp_valid_d = 1'b1;
                  end
               end else begin
                  ram_en  = 1'b1;
                  state_d = LD1;
               end
            end
         end
         LD1: begin
            if (split_q) begin
               hold_d   = ram_rdata;
               ram_en   = 1'b1;
               ram_addr = idx1_q;
               state_d  = LD2;
            end else begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = load_extend({{XLEN{1'b0}}, ram_rdata}, off_q, f3_q);
               state_d     = RESP;
            end
         end
         LD2: begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = load_extend({ram_rdata, hold_q}, off_q, f3_q);
            state_d     = RESP;
         end
         ST2: begin
            ram_en      = 1'b1;
            ram_we      = be_hi_q;
            ram_addr    = idx1_q;
            ram_wdata   = wdata_hi_q;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      ready_d = (state_d == IDLE);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         hold_q      <= '0;
         off_q       <= '0;
         f3_q        <= '0;
         split_q     <= 1'b0;
         idx1_q      <= '0;
         wdata_hi_q  <= '0;
         be_hi_q     <= '0;
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         hold_q      <= hold_d;
         off_q       <= off_d;
         f3_q        <= f3_d;
         split_q     <= split_d;
         idx1_q      <= idx1_d;
         wdata_hi_q  <= wdata_hi_d;
         be_hi_q     <= be_hi_d;
      end
   end

   // Writes are suppressed in a reset cycle so an in-flight second beat is dropped
   dmem_bram #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_bram (
      .clk     (clk),
      .en_i    (ram_en),
      .we_i    (ram_we & {NB{~rst}}),
      .addr_i  (ram_addr),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

   assign req_ready = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_split_ctrl.sv
// Bench for dmem_split_ctrl (XLEN=64, DEPTH=256): directed and random accesses
// compared against a byte-array model of the memory.
module tb_dmem_split_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [63:0] req_addr;
   logic [2:0]  req_func3;
   logic [63:0] req_wdata;
   logic        rsp_valid;
   logic [63:0] rsp_rdata;
   logic        rsp_err;

   int          checks   = 0;
   int          failures = 0;
   logic [7:0]  mem_m [0:2047];
   logic [63:0] last_rd;

   dmem_split_ctrl #(.XLEN(64), .DEPTH(256), .ADDR_W(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_func3 (req_func3),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int m_size(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic logic m_fault(input logic we, input logic [63:0] addr, input logic [2:0] f3);
      int n = m_size(f3);
      return (f3 == 3'b111) || (we && f3[2]) || (addr >= 64'd2048) ||
             ((addr + 64'(n)) > 64'd2048);
   endfunction

   function automatic int m_lat(input logic we, input logic [63:0] addr, input logic [2:0] f3,
                                input logic flt);
      logic two;
      if (flt) return 1;
      two = (int'(addr[2:0]) + m_size(f3)) > 8;
      if (we) return two ? 2 : 1;
      return two ? 3 : 2;
   endfunction

   function automatic logic [63:0] m_load(input logic [63:0] addr, input logic [2:0] f3);
      int n = m_size(f3);
      logic [63:0] v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mem_m[int'(addr) + i];
      if (!f3[2] && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
      return v;
   endfunction

   task automatic m_store(input logic [63:0] addr, input logic [2:0] f3, input logic [63:0] wd);
      for (int i = 0; i < m_size(f3); i++) mem_m[int'(addr) + i] = wd[8*i +: 8];
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic wait_ready();
      int guard = 0;
      while (!req_ready && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
   endtask

   task automatic txn(input logic we, input logic [63:0] addr, input logic [2:0] f3,
                      input logic [63:0] wd, output logic [63:0] rd, output logic err,
                      output int lat);
      wait_ready();
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_func3 = f3;
      req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!rsp_valid) lat = 99;
      rd  = rsp_rdata;
      err = rsp_err;
   endtask

   task automatic run(input string tag, input logic we, input logic [63:0] addr,
                      input logic [2:0] f3, input logic [63:0] wd);
      logic [63:0] exp_rd, rd;
      logic        exp_err, err;
      int          exp_lat, lat;
      exp_err = m_fault(we, addr, f3);
      exp_lat = m_lat(we, addr, f3, exp_err);
      exp_rd  = (exp_err || we) ? 64'd0 : m_load(addr, f3);
      if (!exp_err && we) m_store(addr, f3, wd);
      txn(we, addr, f3, wd, rd, err, lat);
      last_rd = rd;
      check({tag, " rdata"}, rd, exp_rd);
      check({tag, " err"}, 64'(err), 64'(exp_err));
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      @(posedge clk); #1;
      check({tag, " pulse width"}, 64'(rsp_valid), 64'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [63:0] wd;
      int          acc1, acc2, rsp1, rsp2;
      logic        rdy, seen;
      logic [63:0] rd1, rd2, exp1, exp2;

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
      req_addr = '0; req_func3 = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      check("reset req_ready", 64'(req_ready), 64'd1);
      check("reset rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset rsp_err",   64'(rsp_err),   64'd0);
      check("reset rsp_rdata", rsp_rdata,      64'd0);

      // Known contents for every word
      for (int w = 0; w < 256; w++) run("init", 1'b1, 64'(w * 8), 3'b011, {$urandom, $urandom});

      // Aligned SD / LD
      run("sd 0x10", 1'b1, 64'h10, 3'b011, 64'h1122334455667788);
      run("ld 0x10", 1'b0, 64'h10, 3'b011, 64'd0);
      check("ld 0x10 value", last_rd, 64'h1122334455667788);

      // Split SW / LW / LWU
      run("sw 0x0e", 1'b1, 64'h0E, 3'b010, 64'h00000000DEADBEEF);
      run("lw 0x0e", 1'b0, 64'h0E, 3'b010, 64'd0);
      check("lw 0x0e value", last_rd, 64'hFFFFFFFFDEADBEEF);
      run("lwu 0x0e", 1'b0, 64'h0E, 3'b110, 64'd0);
      check("lwu 0x0e value", last_rd, 64'h00000000DEADBEEF);

      // Byte lanes and sign
      run("sb 0x23", 1'b1, 64'h23, 3'b000, 64'h80);
      run("lb 0x23", 1'b0, 64'h23, 3'b000, 64'd0);
      check("lb 0x23 value", last_rd, 64'hFFFFFFFFFFFFFF80);
      run("lbu 0x23", 1'b0, 64'h23, 3'b100, 64'd0);
      check("lbu 0x23 value", last_rd, 64'h80);
      run("lbu 0x22", 1'b0, 64'h22, 3'b100, 64'd0);
      run("lbu 0x24", 1'b0, 64'h24, 3'b100, 64'd0);
      run("ld 0x20",  1'b0, 64'h20, 3'b011, 64'd0);

      // Upper boundary and illegal encodings
      run("sd 0x7fc fault", 1'b1, 64'h7FC, 3'b011, 64'hCAFEF00DCAFEF00D);
      run("ld word 255",    1'b0, 64'h7F8, 3'b011, 64'd0);
      run("ld 0x7f8 last",  1'b0, 64'h7F8, 3'b011, 64'd0);
      run("lb 0x800 fault", 1'b0, 64'h800, 3'b000, 64'd0);
      run("lb huge fault",  1'b0, 64'hFFFFFFFFFFFFFFFF, 3'b000, 64'd0);
      run("store f3 100",   1'b1, 64'h30, 3'b100, 64'h55);
      run("load f3 111",    1'b0, 64'h30, 3'b111, 64'd0);
      run("ld 0x30 intact", 1'b0, 64'h30, 3'b011, 64'd0);

      // Reset while a split store is in flight
      wd = 64'hA5A55A5A0F0FF0F0;
      wait_ready();
      req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h44; req_func3 = 3'b011; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid-rst rsp_valid", 64'(rsp_valid), 64'd0);
      check("mid-rst req_ready", 64'(req_ready), 64'd1);
      seen = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         seen = seen | rsp_valid;
      end
      check("mid-rst no response", 64'(seen), 64'd0);
      for (int i = 0; i < 4; i++) mem_m[16'h44 + i] = wd[8*i +: 8];
      run("mid-rst word w",   1'b0, 64'h40, 3'b011, 64'd0);
      run("mid-rst word w+1", 1'b0, 64'h48, 3'b011, 64'd0);

      // Back-to-back with req_valid held: split LD then LBU
      exp1 = m_load(64'h104, 3'b011);
      exp2 = m_load(64'h105, 3'b100);
      acc1 = -1; acc2 = -1; rsp1 = -1; rsp2 = -1; rd1 = '0; rd2 = '0;
      wait_ready();
      req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h104; req_func3 = 3'b011; req_wdata = '0;
      for (int c = 0; c < 16; c++) begin
         rdy = req_ready;
         @(posedge clk); #1;
         if (rdy && req_valid) begin
            if (acc1 < 0) begin
               acc1 = c;
               req_addr = 64'h105; req_func3 = 3'b100;
            end else if (acc2 < 0) begin
               acc2 = c;
               req_valid = 1'b0;
            end
         end
         if (rsp_valid) begin
            if (rsp1 < 0) begin
               rsp1 = c + 1; rd1 = rsp_rdata;
            end else if (rsp2 < 0) begin
               rsp2 = c + 1; rd2 = rsp_rdata;
            end
         end
      end
      req_valid = 1'b0;
      check("b2b first rsp timing",  64'(rsp1 - acc1), 64'd3);
      check("b2b second accept",     64'(acc2 - rsp1), 64'd1);
      check("b2b second rsp timing", 64'(rsp2 - acc2), 64'd2);
      check("b2b first data",  rd1, exp1);
      check("b2b second data", rd2, exp2);

      // Random mix of loads/stores, alignments and faults
      for (int k = 0; k < 80; k++) begin
         run("random", 1'($urandom_range(0, 1)), 64'($urandom_range(0, 2079)),
             3'($urandom_range(0, 7)), {$urandom, $urandom});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
